tube_scan_capture: RTL and testbench
====================================

Name: tube_scan_capture

Overview:
- Receive side of the board's 8-digit seven-segment scan interface. Observes the multiplexed, active-low digit-select (DIG) and segment (Y) lines that Top drives.
- Decodes each scanned glyph back to a hex nibble and assembles a full 32-bit display frame.
- Used in benches and on a monitor board to read back what the CPU displays, without probing internal registers.

Parameters:
- STABLE_CYCLES, 4: consecutive clk cycles with identical dig/y required before a digit is sampled (min 1).
- NUM_DIGITS, 8: number of scanned digit positions; value width = 4*NUM_DIGITS.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- dig  in  8  digit select, active-low; bit i low selects digit i (digit 0 = least-significant nibble)
- y  in  8  segments, active-low: y[0]=a … y[6]=g, y[7]=dp
- value  out  32  last complete frame; nibble i = digit i
- blank_mask  out  8  bit i = 1: digit i was blank (all of a–g off); its nibble reads 0
- dp_mask  out  8  bit i = 1: decimal point lit on digit i
- err_mask  out  8  bit i = 1: digit i showed an undecodable pattern; its nibble reads 0
- frame_valid  out  1  one-cycle pulse when value/masks update

Behaviour:
- Reset: async on rst high. All outputs 0, stability counter 0, shadow registers 0, seen-mask 0, FSM in COLLECT. Reset mid-frame discards the partial frame.
- Valid select: dig is one-cold (exactly one bit 0). dig = 8'hFF is inter-digit blanking; any other multi-zero value is a glitch.
- Stability counter:
  - Registers previous {dig, y} each cycle.
  - If the current value equals the previous one and dig is one-cold, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the counter resets to 1 if dig is one-cold, else 0.
  - A sample strobe fires on the cycle the counter transitions to STABLE_CYCLES. This gives exactly one sample per dwell; a long dwell does not re-sample.
- Glyph decode is active-high on ~y[6:0] (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - 00 decodes as blank.
  - Anything else is an error.
  - dp = ~y[7], independent of the glyph.
- FSM states COLLECT and PUBLISH:
  - COLLECT: on a strobe for digit i, write shadow nibble/blank/dp/err for digit i and set seen[i]. A repeated digit overwrites its shadow entry (newest wins). When seen becomes all ones, go to PUBLISH.
  - PUBLISH (exactly one cycle): copy shadows to outputs, assert frame_valid, clear seen, return to COLLECT.
  - Latency: frame_valid is high in the cycle after the edge that sampled the last missing digit.
  - A strobe that arrives during PUBLISH is captured into the shadow and into the new seen mask. No sample is lost.
- Outputs hold their value between frames.
- A glitch or blanking interval between digits never breaks frame assembly; it only restarts the stability count.
- Digit order is irrelevant; any scan order completes a frame once all 8 digits are seen.

Decomposition:
- Package seg_pkg:
  - GLYPH_0..GLYPH_F 7-bit active-high constants
  - GLYPH_BLANK = 7'h00
  - SEG_DP index 7
  - Typedef for the per-digit record {nibble[3:0], blank, dp, err}
- Sub-module seg_glyph_decode (combinational): input 8-bit active-low y; outputs nibble, blank, dp, err.
- Instance it once on the live y input.

Test Plan:
- Reset, then scan digits 0..7 showing 1,2,3,4,5,6,7,8 (y = ~{0,glyph}), 6 cycles each, dig one-cold → frame_valid one cycle after the digit-7 sample; value = 32'h87654321; blank/dp/err masks = 0.
- Same scan with 2-cycle dwells and STABLE_CYCLES=4 → no strobes, frame_valid never asserts; then lengthen to 4 cycles → frame at the 4th cycle of the last digit.
- Digit 3 shows all segments off, digit 5 lights dp with glyph A, digit 6 shows y[6:0]=~7'h01 → value nibble3 = 0, nibble5 = A, nibble6 = 0; blank_mask = 8'h08, dp_mask = 8'h20, err_mask = 8'h40.
- Insert dig = 8'hFF and dig = 8'hFC glitches (1 cycle) mid-dwell → stability restarts; correct value still published; no spurious strobe for the glitch.
- Reverse scan order 7..0, with digit 2 repeated showing 9 after first showing 4 → value reflects 9 at nibble 2; exactly one frame_valid per complete set.
- Assert rst for 1 cycle after digits 0..5 → all outputs 0; following full scan of F's → value = 32'hFFFFFFFF, single frame_valid.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared glyph constants and per-digit record for the seven-segment scan capture.
// Glyph bit order is gfedcba, active-high.
package seg_pkg;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_A     = 7'h77;
   localparam logic [6:0] GLYPH_B     = 7'h7C;
   localparam logic [6:0] GLYPH_C     = 7'h39;
   localparam logic [6:0] GLYPH_D     = 7'h5E;
   localparam logic [6:0] GLYPH_E     = 7'h79;
   localparam logic [6:0] GLYPH_F     = 7'h71;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   localparam int SEG_DP = 7;

   typedef struct packed {
      logic [3:0] nibble;
      logic       blank;
      logic       dp;
      logic       err;
   } digit_rec_t;

   typedef enum logic {
      ST_COLLECT,
      ST_PUBLISH
   } cap_state_e;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational decode of one active-low segment pattern into a hex nibble.
// Blank and undecodable patterns both read back as nibble 0.
module seg_glyph_decode
   import seg_pkg::*;
(
   input  logic [7:0] y_i,
   output logic [3:0] nibble_o,
   output logic       blank_o,
   output logic       dp_o,
   output logic       err_o
);

   logic [6:0] seg;

   always_comb begin
      seg      = ~y_i[6:0];
      nibble_o = 4'h0;
      blank_o  = 1'b0;
      err_o    = 1'b0;
      dp_o     = ~y_i[SEG_DP];
      case (seg)
         GLYPH_0:     nibble_o = 4'h0;
         GLYPH_1:     nibble_o = 4'h1;
         GLYPH_2:     nibble_o = 4'h2;
         GLYPH_3:     nibble_o = 4'h3;
         GLYPH_4:     nibble_o = 4'h4;
         GLYPH_5:     nibble_o = 4'h5;
         GLYPH_6:     nibble_o = 4'h6;
         GLYPH_7:     nibble_o = 4'h7;
         GLYPH_8:     nibble_o = 4'h8;
         GLYPH_9:     nibble_o = 4'h9;
         GLYPH_A:     nibble_o = 4'hA;
         GLYPH_B:     nibble_o = 4'hB;
         GLYPH_C:     nibble_o = 4'hC;
         GLYPH_D:     nibble_o = 4'hD;
         GLYPH_E:     nibble_o = 4'hE;
         GLYPH_F:     nibble_o = 4'hF;
         GLYPH_BLANK: blank_o  = 1'b1;
         default:     err_o    = 1'b1;
      endcase
   end

endmodule

// File: rtl/tube_scan_capture.sv
// Reconstructs the displayed hex frame from the multiplexed, active-low digit/segment
// scan lines: one sample per stable dwell, published once every digit has been seen.
module tube_scan_capture
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int NUM_DIGITS    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   dig,
   input  logic [7:0]              y,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [NUM_DIGITS-1:0]   dp_mask,
   output logic [NUM_DIGITS-1:0]   err_mask,
   output logic                    frame_valid
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int ZW    = $clog2(NUM_DIGITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   logic [NUM_DIGITS+7:0]   prev_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   cap_state_e              state_q, state_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic [4*NUM_DIGITS-1:0] nib_sh_q, nib_sh_d;
   logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
   logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [NUM_DIGITS-1:0]   err_sh_q, err_sh_d;
   logic [4*NUM_DIGITS-1:0] value_q, value_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
   logic [NUM_DIGITS-1:0]   errm_q, errm_d;
   logic                    fv_q, fv_d;

   logic [ZW-1:0]    zeros;
   logic [IDX_W-1:0] sel_idx;
   logic             one_cold;
   logic             same;
   logic             strobe;
   logic             go_pub;
   logic [3:0]       dec_nibble;
   logic             dec_blank, dec_dp, dec_err;

   seg_glyph_decode u_decode (
      .y_i      (y),
      .nibble_o (dec_nibble),
      .blank_o  (dec_blank),
      .dp_o     (dec_dp),
      .err_o    (dec_err)
   );

   always_comb begin
      zeros   = '0;
      sel_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!dig[i]) begin
            zeros   = zeros + ZW'(1);
            sel_idx = IDX_W'(i);
         end
      end
      one_cold = (zeros == ZW'(1));
   end

   // Strobe only on the transition into CNT_MAX, so a long dwell samples once.
   always_comb begin
      same = ({dig, y} == prev_q);
      if (same && one_cold) begin
         cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      end else begin
         cnt_d = one_cold ? CNT_W'(1) : '0;
      end
      strobe = (cnt_d == CNT_MAX) && !(same && (cnt_q == CNT_MAX));
   end

   always_comb begin
      nib_sh_d   = nib_sh_q;
      blank_sh_d = blank_sh_q;
      dp_sh_d    = dp_sh_q;
      err_sh_d   = err_sh_q;
      seen_d     = (state_q == ST_PUBLISH) ? '0 : seen_q;
      if (strobe) begin
         nib_sh_d[{sel_idx, 2'b00} +: 4] = dec_nibble;
         blank_sh_d[sel_idx]             = dec_blank;
         dp_sh_d[sel_idx]                = dec_dp;
         err_sh_d[sel_idx]               = dec_err;
         seen_d[sel_idx]                 = 1'b1;
      end
      go_pub  = (state_q == ST_COLLECT) && (&seen_d);
      state_d = go_pub ? ST_PUBLISH : ST_COLLECT;
      // Outputs load from the next-state shadows so the final digit is included.
      value_d = go_pub ? nib_sh_d   : value_q;
      blank_d = go_pub ? blank_sh_d : blank_q;
      dpm_d   = go_pub ? dp_sh_d    : dpm_q;
      errm_d  = go_pub ? err_sh_d   : errm_q;
      fv_d    = go_pub;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q     <= '0;
         cnt_q      <= '0;
         state_q    <= ST_COLLECT;
         seen_q     <= '0;
         nib_sh_q   <= '0;
         blank_sh_q <= '0;
         dp_sh_q    <= '0;
         err_sh_q   <= '0;
         value_q    <= '0;
         blank_q    <= '0;
         dpm_q      <= '0;
         errm_q     <= '0;
         fv_q       <= 1'b0;
      end else begin
         prev_q     <= {dig, y};
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         seen_q     <= seen_d;
         nib_sh_q   <= nib_sh_d;
         blank_sh_q <= blank_sh_d;
         dp_sh_q    <= dp_sh_d;
         err_sh_q   <= err_sh_d;
         value_q    <= value_d;
         blank_q    <= blank_d;
         dpm_q      <= dpm_d;
         errm_q     <= errm_d;
         fv_q       <= fv_d;
      end
   end

   assign value       = value_q;
   assign blank_mask  = blank_q;
   assign dp_mask     = dpm_q;
   assign err_mask    = errm_q;
   assign frame_valid = fv_q;

endmodule

// File: tb/tb_tube_scan_capture.sv
// Scoreboard bench for tube_scan_capture: scans push the expected frame and its
// publish cycle; a negedge monitor pops and compares each frame_valid pulse.
module tb_tube_scan_capture;

   localparam int SC = 4;

   typedef struct {
      logic [31:0] v;
      logic [7:0]  b;
      logic [7:0]  d;
      logic [7:0]  e;
      int          at;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  dig;
   logic [7:0]  y;
   logic [31:0] value;
   logic [7:0]  blank_mask, dp_mask, err_mask;
   logic        frame_valid;

   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   n_frames = 0;
   exp_t sb[$];

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   tube_scan_capture #(.STABLE_CYCLES(SC), .NUM_DIGITS(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .dig         (dig),
      .y           (y),
      .value       (value),
      .blank_mask  (blank_mask),
      .dp_mask     (dp_mask),
      .err_mask    (err_mask),
      .frame_valid (frame_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] yon(int n, bit dp);
      return ~{dp, glyph[n]};
   endfunction

   task automatic drive(int idx, logic [7:0] yv, int n);
      dig = ~(8'd1 << idx);
      y   = yv;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      dig = 8'hFF;
      y   = 8'hFF;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just before driving the digit that completes a frame.
   task automatic push_exp(logic [31:0] v, logic [7:0] b, logic [7:0] d, logic [7:0] e);
      exp_t x;
      x.v  = v;
      x.b  = b;
      x.d  = d;
      x.e  = e;
      x.at = cyc + SC;
      sb.push_back(x);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && frame_valid !== 1'b0) begin
         exp_t x;
         n_frames++;
         n_assert++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: value=%h at cycle %0d, no frame expected", value, cyc);
         end else begin
            x = sb.pop_front();
            if (value !== x.v) begin
               n_fail++;
               $display("FAIL frame_value: got %h expected %h", value, x.v);
            end
            n_assert++;
            if ({blank_mask, dp_mask, err_mask} !== {x.b, x.d, x.e}) begin
               n_fail++;
               $display("FAIL frame_masks: got b=%h d=%h e=%h expected b=%h d=%h e=%h",
                        blank_mask, dp_mask, err_mask, x.b, x.d, x.e);
            end
            n_assert++;
            if (cyc !== x.at) begin
               n_fail++;
               $display("FAIL frame_latency: got cycle %0d expected cycle %0d", cyc, x.at);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      dig = 8'hFF;
      y   = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      n_assert++;
      if ({value, blank_mask, dp_mask, err_mask, frame_valid} !== 57'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got value=%h b=%h d=%h e=%h fv=%b expected all 0",
                  value, blank_mask, dp_mask, err_mask, frame_valid);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_basic();
      int f0 = n_frames;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) push_exp(32'h87654321, 8'h00, 8'h00, 8'h00);
         drive(i, yon(i + 1, 1'b0), 6);
      end
      idle(3);
      n_assert++;
      if (n_frames - f0 !== 1) begin
         n_fail++;
         $display("FAIL basic_frame_count: got %0d expected 1", n_frames - f0);
      end
      idle(4);
      n_assert++;
      if (value !== 32'h87654321) begin
         n_fail++;
         $display("FAIL basic_hold: got %h expected 87654321", value);
      end
   endtask

   task automatic test_dwell();
      int f0 = n_frames;
      for (int i = 0; i < 8; i++) drive(i, yon(i + 1, 1'b0), 2);
      idle(2);
      n_assert++;
      if (n_frames !== f0) begin
         n_fail++;
         $display("FAIL short_dwell_frames: got %0d expected 0", n_frames - f0);
      end
      for (int i = 0; i < 8; i++) begin
         if (i == 7) push_exp(32'h87654321, 8'h00, 8'h00, 8'h00);
         drive(i, yon(i + 1, 1'b0), 4);
      end
      idle(3);
      n_assert++;
      if (n_frames - f0 !== 1) begin
         n_fail++;
         $display("FAIL min_dwell_frames: got %0d expected 1", n_frames - f0);
      end
   endtask

   task automatic test_masks();
      int f0 = n_frames;
      logic [7:0] ys [8];
      ys[0] = yon(1, 1'b0);
      ys[1] = yon(2, 1'b0);
      ys[2] = yon(3, 1'b0);
      ys[3] = 8'hFF;
      ys[4] = yon(5, 1'b0);
      ys[5] = yon(10, 1'b1);
      ys[6] = 8'hFE;
      ys[7] = yon(8, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) push_exp(32'h80A50321, 8'h08, 8'h20, 8'h40);
         drive(i, ys[i], 6);
      end
      idle(3);
      n_assert++;
      if (n_frames - f0 !== 1) begin
         n_fail++;
         $display("FAIL masks_frame_count: got %0d expected 1", n_frames - f0);
      end
   endtask

   task automatic test_glitch();
      int f0 = n_frames;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) push_exp(32'hFEDCBA98, 8'h00, 8'h00, 8'h00);
         if (i == 2 || i == 5) begin
            drive(i, yon(i + 8, 1'b0), 2);
            dig = (i == 2) ? 8'hFF : 8'hFC;
            @(posedge clk);
            #1;
            drive(i, yon(i + 8, 1'b0), 5);
         end else begin
            drive(i, yon(i + 8, 1'b0), 6);
         end
      end
      idle(3);
      n_assert++;
      if (n_frames - f0 !== 1) begin
         n_fail++;
         $display("FAIL glitch_frame_count: got %0d expected 1", n_frames - f0);
      end
   endtask

   task automatic test_reverse();
      int f0 = n_frames;
      for (int i = 7; i >= 0; i--) begin
         if (i == 2) begin
            drive(2, yon(4, 1'b0), 6);
            drive(2, yon(9, 1'b0), 6);
         end else begin
            if (i == 0) push_exp(32'h76543910, 8'h00, 8'h00, 8'h00);
            drive(i, yon(i, 1'b0), 6);
         end
      end
      idle(3);
      n_assert++;
      if (n_frames - f0 !== 1) begin
         n_fail++;
         $display("FAIL reverse_frame_count: got %0d expected 1", n_frames - f0);
      end
   endtask

   task automatic test_midreset();
      int f0;
      for (int i = 0; i < 6; i++) drive(i, yon(1, 1'b0), 6);
      rst = 1'b1;
      #1;
      n_assert++;
      if ({value, blank_mask, dp_mask, err_mask, frame_valid} !== 57'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got value=%h b=%h d=%h e=%h fv=%b expected all 0",
                  value, blank_mask, dp_mask, err_mask, frame_valid);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      f0 = n_frames;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) push_exp(32'hFFFFFFFF, 8'h00, 8'h00, 8'h00);
         drive(i, yon(15, 1'b0), 6);
      end
      idle(3);
      n_assert++;
      if (n_frames - f0 !== 1) begin
         n_fail++;
         $display("FAIL midreset_frame_count: got %0d expected 1", n_frames - f0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dwell();
      test_masks();
      test_glitch();
      test_reverse();
      test_midreset();
      idle(4);
      n_assert++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL missing_frames: %0d expected frames never published", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
